// File: rtl/demux_4_stream.sv
// demux_4_stream: registered 1-to-4 valid/ready stream demultiplexer.
// A source beat is steered to one of four destination ports. Each port has a
// one-entry output register. Multi-beat bursts lock the select from the first
// beat until the beat flagged last.
//
// Ports:
//   clk, rst_n            clock, synchronous active-low reset
//   s_valid/s_ready       source handshake
//   s_data, s_sel, s_last source beat data, destination select, end of burst
//   m_valid[3:0]          per-port valid (bit i = port i)
//   m_ready[3:0]          per-port ready (bit i = port i)
//   m_data0..m_data3      per-port data
//   burst_active          high while a burst holds the select locked
//   beat_count            beats accepted in the current burst, saturating at 255
module demux_4_stream #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             s_valid,
    output logic             s_ready,
    input  logic [WIDTH-1:0] s_data,
    input  logic [1:0]       s_sel,
    input  logic             s_last,
    output logic [3:0]       m_valid,
    input  logic [3:0]       m_ready,
    output logic [WIDTH-1:0] m_data0,
    output logic [WIDTH-1:0] m_data1,
    output logic [WIDTH-1:0] m_data2,
    output logic [WIDTH-1:0] m_data3,
    output logic             burst_active,
    output logic [7:0]       beat_count
);

    typedef enum logic [0:0] {StIdle, StLocked} state_e;

    state_e           state_q, state_d;
    logic [1:0]       lock_sel_q, lock_sel_d;
    logic [7:0]       beat_count_q, beat_count_d;
    logic [3:0]       m_valid_q, m_valid_d;
    logic [WIDTH-1:0] m_data_q [4];
    logic [WIDTH-1:0] m_data_d [4];

    logic [1:0] tgt;
    logic       accept;

    // Only the target port's occupancy and ready feed s_ready, so there is no
    // combinational path from a non-target m_ready to the source.
    assign tgt     = (state_q == StLocked) ? lock_sel_q : s_sel;
    assign s_ready = rst_n & (~m_valid_q[tgt] | m_ready[tgt]);
    assign accept  = s_valid & s_ready;

    // State register (synchronous reset)
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= StIdle;
            lock_sel_q   <= 2'd0;
            beat_count_q <= 8'd0;
            m_valid_q    <= 4'b0000;
            for (int i = 0; i < 4; i++) begin
                m_data_q[i] <= '0;
            end
        end else begin
            state_q      <= state_d;
            lock_sel_q   <= lock_sel_d;
            beat_count_q <= beat_count_d;
            m_valid_q    <= m_valid_d;
            for (int i = 0; i < 4; i++) begin
                m_data_q[i] <= m_data_d[i];
            end
        end
    end

    // Next-state logic: burst FSM and counter
    always_comb begin
        state_d      = state_q;
        lock_sel_d   = lock_sel_q;
        beat_count_d = beat_count_q;
        unique case (state_q)
            StIdle: begin
                if (accept) begin
                    if (s_last) begin
                        beat_count_d = 8'd0;
                    end else begin
                        state_d      = StLocked;
                        lock_sel_d   = s_sel;
                        beat_count_d = 8'd1;
                    end
                end
            end
            StLocked: begin
                if (accept) begin
                    if (s_last) begin
                        state_d      = StIdle;
                        beat_count_d = 8'd0;
                    end else if (beat_count_q != 8'hff) begin
                        beat_count_d = beat_count_q + 8'd1;
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // Next-state logic: per-port output registers. A load wins over a drain,
    // which keeps valid high for back-to-back beats.
    always_comb begin
        m_valid_d = m_valid_q;
        for (int i = 0; i < 4; i++) begin
            m_data_d[i] = m_data_q[i];
            if (accept && (tgt == 2'(i))) begin
                m_valid_d[i] = 1'b1;
                m_data_d[i]  = s_data;
            end else if (m_ready[i]) begin
                m_valid_d[i] = 1'b0;
            end
        end
    end

    // Outputs
    always_comb begin
        burst_active = (state_q == StLocked);
        beat_count   = beat_count_q;
        m_valid      = m_valid_q;
        m_data0      = m_data_q[0];
        m_data1      = m_data_q[1];
        m_data2      = m_data_q[2];
        m_data3      = m_data_q[3];
    end

endmodule

// File: tb/tb_demux_4_stream.sv
// Directed testbench for demux_4_stream.
module tb_demux_4_stream;

    logic        clk;
    logic        rst_n;
    logic        s_valid;
    logic        s_ready;
    logic [31:0] s_data;
    logic [1:0]  s_sel;
    logic        s_last;
    logic [3:0]  m_valid;
    logic [3:0]  m_ready;
    logic [31:0] m_data0, m_data1, m_data2, m_data3;
    logic        burst_active;
    logic [7:0]  beat_count;

    int total = 0;
    int bad   = 0;

    demux_4_stream #(.WIDTH(32)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .s_valid      (s_valid),
        .s_ready      (s_ready),
        .s_data       (s_data),
        .s_sel        (s_sel),
        .s_last       (s_last),
        .m_valid      (m_valid),
        .m_ready      (m_ready),
        .m_data0      (m_data0),
        .m_data1      (m_data1),
        .m_data2      (m_data2),
        .m_data3      (m_data3),
        .burst_active (burst_active),
        .beat_count   (beat_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%h expected=%h", tag, got, exp);
        end
    endtask

    // Advance one edge; registered outputs are stable 2 ns later.
    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic beat(input logic [1:0] sel, input logic [31:0] data, input logic last);
        s_valid = 1'b1;
        s_sel   = sel;
        s_data  = data;
        s_last  = last;
    endtask

    initial begin
        rst_n   = 1'b0;
        s_valid = 1'b1;
        s_data  = 32'h0;
        s_sel   = 2'd0;
        s_last  = 1'b1;
        m_ready = 4'b0000;

        // Reset held with a pending source beat
        tick();
        tick();
        #1;
        check("rst_s_ready", 32'(s_ready), 32'd0);
        check("rst_m_valid", 32'(m_valid), 32'd0);
        check("rst_beat_count", 32'(beat_count), 32'd0);
        check("rst_burst", 32'(burst_active), 32'd0);
        check("rst_m_data0", m_data0, 32'd0);
        rst_n   = 1'b1;
        s_valid = 1'b0;
        tick();
        check("post_rst_m_valid", 32'(m_valid), 32'd0);
        check("post_rst_beat_count", 32'(beat_count), 32'd0);

        // Single beat to port 2
        m_ready = 4'b1111;
        beat(2'd2, 32'hA5A5_0001, 1'b1);
        #1;
        check("single_s_ready", 32'(s_ready), 32'd1);
        tick();
        s_valid = 1'b0;
        check("single_m_valid", 32'(m_valid), 32'b0100);
        check("single_m_data2", m_data2, 32'hA5A5_0001);
        check("single_burst", 32'(burst_active), 32'd0);
        tick();
        check("single_drain", 32'(m_valid), 32'd0);
        check("single_hold", m_data2, 32'hA5A5_0001);

        // Backpressure on port 1
        m_ready = 4'b0000;
        beat(2'd1, 32'h0000_0011, 1'b1);
        tick();
        s_data = 32'h0000_0022;
        #1;
        check("bp_stall", 32'(s_ready), 32'd0);
        check("bp_m_valid", 32'(m_valid), 32'b0010);
        tick();
        check("bp_hold_data", m_data1, 32'h0000_0011);
        m_ready = 4'b0010;
        #1;
        check("bp_release", 32'(s_ready), 32'd1);
        tick();
        s_valid = 1'b0;
        m_ready = 4'b0000;
        check("bp_refill_valid", 32'(m_valid), 32'b0010);
        check("bp_refill_data", m_data1, 32'h0000_0022);
        m_ready = 4'b1111;
        tick();
        check("bp_empty", 32'(m_valid), 32'd0);

        // Four-beat burst locked to port 3
        beat(2'd3, 32'h0000_00B0, 1'b0);
        tick();
        check("burst1_active", 32'(burst_active), 32'd1);
        check("burst1_count", 32'(beat_count), 32'd1);
        check("burst1_data", m_data3, 32'h0000_00B0);
        beat(2'd0, 32'h0000_00B1, 1'b0);
        tick();
        check("burst2_count", 32'(beat_count), 32'd2);
        check("burst2_valid", 32'(m_valid), 32'b1000);
        check("burst2_data", m_data3, 32'h0000_00B1);
        beat(2'd0, 32'h0000_00B2, 1'b0);
        tick();
        check("burst3_count", 32'(beat_count), 32'd3);
        beat(2'd0, 32'h0000_00B3, 1'b1);
        tick();
        s_valid = 1'b0;
        check("burst4_count", 32'(beat_count), 32'd0);
        check("burst4_active", 32'(burst_active), 32'd0);
        check("burst4_data", m_data3, 32'h0000_00B3);
        check("burst_port0_untouched", m_data0, 32'd0);
        tick();

        // Independent drain of ports 0 and 2
        m_ready = 4'b0000;
        beat(2'd0, 32'h0000_00C0, 1'b1);
        tick();
        beat(2'd2, 32'h0000_00C2, 1'b1);
        tick();
        s_valid = 1'b0;
        check("ind_loaded", 32'(m_valid), 32'b0101);
        m_ready = 4'b0101;
        tick();
        check("ind_drained", 32'(m_valid), 32'd0);
        m_ready = 4'b0000;
        beat(2'd0, 32'h0000_00D0, 1'b1);
        tick();
        s_data = 32'h0000_00D1;
        #1;
        check("ind_port0_stall", 32'(s_ready), 32'd0);
        s_sel = 2'd1;
        #1;
        check("ind_sel_follow", 32'(s_ready), 32'd1);
        tick();
        s_valid = 1'b0;
        check("ind_both_full", 32'(m_valid), 32'b0011);
        check("ind_m_data1", m_data1, 32'h0000_00D1);
        check("ind_m_data0", m_data0, 32'h0000_00D0);
        m_ready = 4'b1111;
        tick();

        // Long burst: saturation, then reset mid-burst
        for (int i = 0; i < 300; i++) begin
            beat(2'd2, 32'(i), 1'b0);
            tick();
            if (i == 199) begin
                check("sat_count_200", 32'(beat_count), 32'd200);
            end
        end
        check("sat_count", 32'(beat_count), 32'd255);
        check("sat_active", 32'(burst_active), 32'd1);
        check("sat_data", m_data2, 32'd299);
        rst_n   = 1'b0;
        s_valid = 1'b0;
        #1;
        check("mid_rst_s_ready", 32'(s_ready), 32'd0);
        tick();
        rst_n = 1'b1;
        check("mid_rst_active", 32'(burst_active), 32'd0);
        check("mid_rst_valid", 32'(m_valid), 32'd0);
        check("mid_rst_count", 32'(beat_count), 32'd0);
        check("mid_rst_data2", m_data2, 32'd0);
        beat(2'd1, 32'h0000_00E1, 1'b1);
        tick();
        s_valid = 1'b0;
        check("fresh_sel_valid", 32'(m_valid), 32'b0010);
        check("fresh_sel_data1", m_data1, 32'h0000_00E1);
        check("fresh_sel_data2", m_data2, 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
